// File: rtl/pb_debouncer_pkg.sv
// Shared types and sizing helpers for the
// push-button debouncer array.
package pb_debouncer_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_CNT = 3'd1,
    ST_PRESS_PE  = 3'd2,
    ST_HELD      = 3'd3,
    ST_REL_CNT   = 3'd4,
    ST_REL_NE    = 3'd5
  } pb_state_e;

  function automatic int max_i(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pb_debouncer_array_if.sv
// Pad-side bundle: raw buttons in, conditioned
// levels and pulses out.
interface pb_debouncer_array_if #(
  parameter int N_CH = 5
) ();

  logic [N_CH-1:0] pb;
  logic [N_CH-1:0] pb_state;
  logic [N_CH-1:0] pb_posedge;
  logic [N_CH-1:0] pb_negedge;
  logic [N_CH-1:0] pb_repeat;

  modport master (
    output pb,
    input  pb_state,
    input  pb_posedge,
    input  pb_negedge,
    input  pb_repeat
  );

  modport slave (
    input  pb,
    output pb_state,
    output pb_posedge,
    output pb_negedge,
    output pb_repeat
  );

endinterface

// File: rtl/pb_debounce_channel.sv
// One button: 2-FF synchroniser, debounce FSM,
// edge pulses and hold-to-repeat.
module pb_debounce_channel
  import pb_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000,
  parameter int ACTIVE_LOW           = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_i,
  output logic state_o,
  output logic pe_o,
  output logic ne_o,
  output logic rpt_o
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(max_i(REPEAT_DELAY_CYCLES,
                                  REPEAT_PERIOD_CYCLES));
  localparam logic RPT_EN = (REPEAT_DELAY_CYCLES > 0);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST =
    RW'(RPT_EN ? REPEAT_DELAY_CYCLES - 1 : 0);
  // Modular reload: still lands on RPT_LAST after
  // exactly one period even when PERIOD > DELAY.
  localparam logic [RW-1:0] RPT_LOAD =
    RW'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

  logic      s1_q, s1_d;
  logic      s2_q, s2_d;
  pb_state_e state_q, state_d;
  logic [DW-1:0] db_q, db_d;
  logic [RW-1:0] rpt_q, rpt_d;

  always_comb begin
    s1_d = (ACTIVE_LOW != 0) ? ~pb_i : pb_i;
    s2_d = s1_q;
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    rpt_d   = rpt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          state_d = ST_PRESS_CNT;
          db_d    = '0;
        end
      end
      ST_PRESS_CNT: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
        end else if (db_q == DB_LAST) begin
          state_d = ST_PRESS_PE;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      ST_PRESS_PE: begin
        state_d = ST_HELD;
        rpt_d   = '0;
      end
      ST_HELD: begin
        if (RPT_EN) begin
          rpt_d = (rpt_q == RPT_LAST) ?
                  RPT_LOAD : rpt_q + 1'b1;
        end
        if (!s2_q) begin
          state_d = ST_REL_CNT;
          db_d    = '0;
        end
      end
      ST_REL_CNT: begin
        if (s2_q) begin
          state_d = ST_HELD;
        end else if (db_q == DB_LAST) begin
          state_d = ST_REL_NE;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      ST_REL_NE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    state_o = 1'b0;
    pe_o    = 1'b0;
    ne_o    = 1'b0;
    rpt_o   = 1'b0;
    unique case (1'b1)
      (state_q == ST_PRESS_PE): begin
        state_o = 1'b1;
        pe_o    = 1'b1;
      end
      (state_q == ST_HELD): begin
        state_o = 1'b1;
        rpt_o   = RPT_EN && (rpt_q == RPT_LAST);
      end
      (state_q == ST_REL_CNT): begin
        state_o = 1'b1;
      end
      (state_q == ST_REL_NE): begin
        ne_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_IDLE;
      db_q    <= '0;
      rpt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      db_q    <= db_d;
      rpt_q   <= rpt_d;
    end
  end

endmodule

// File: rtl/pb_debouncer_array.sv
// N independent button conditioners sharing one
// clock and reset.
module pb_debouncer_array #(
  parameter int N_CH                 = 5,
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000,
  parameter int ACTIVE_LOW           = 0
) (
  input logic                 clk,
  input logic                 rst,
  pb_debouncer_array_if.slave io
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_debounce_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
      .ACTIVE_LOW          (ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .pb_i   (io.pb[g]),
      .state_o(io.pb_state[g]),
      .pe_o   (io.pb_posedge[g]),
      .ne_o   (io.pb_negedge[g]),
      .rpt_o  (io.pb_repeat[g])
    );
  end

endmodule

// File: tb/tb_pb_debouncer_array.sv
// Directed + random bench for pb_debouncer_array
// against a run-length reference model.
module tb_pb_debouncer_array;

  localparam int DB  = 4;
  localparam int PER = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pb_debouncer_array_if #(.N_CH(2)) ifa ();
  pb_debouncer_array_if #(.N_CH(2)) ifb ();

  pb_debouncer_array #(
    .N_CH(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_PERIOD_CYCLES(PER), .ACTIVE_LOW(0)
  ) u_a (.clk(clk), .rst(rst), .io(ifa.slave));

  pb_debouncer_array #(
    .N_CH(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY_CYCLES(0),
    .REPEAT_PERIOD_CYCLES(PER), .ACTIVE_LOW(1)
  ) u_b (.clk(clk), .rst(rst), .io(ifb.slave));

  // Model: accepted level plus length of the current
  // run of synced samples disagreeing with it.
  typedef struct {
    bit s1, s2, lvl, pulse;
    int run, h;
    bit st, pe, ne, rp;
  } mch_t;

  mch_t m [2][2];
  int   dly [2] = '{20, 0};
  int   alo [2] = '{0, 1};

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;

  int n_pe [2], n_ne [2], n_rp [2], n_st [2];
  int pe_cyc [2], ne_cyc [2], rp_cyc [2];
  int n_both;
  int nb_pe, nb_ne, nb_rp, nb_st, nb_pe_cyc;
  int t0, t1;

  task automatic model_step();
    bit raw, samp, held;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        raw = (i == 0) ? ifa.pb[c] : ifb.pb[c];
        if (alo[i] != 0) raw = !raw;
        if (rst) begin
          m[i][c] = '{default: 0};
          continue;
        end
        samp = m[i][c].s2;
        m[i][c].s2 = m[i][c].s1;
        m[i][c].s1 = raw;
        m[i][c].pe = 0;
        m[i][c].ne = 0;
        if (m[i][c].pulse) begin
          m[i][c].pulse = 0;
          m[i][c].run = 0;
        end else if (samp != m[i][c].lvl) begin
          m[i][c].run++;
          if (m[i][c].run == DB + 1) begin
            m[i][c].lvl = samp;
            m[i][c].run = 0;
            m[i][c].pulse = 1;
            m[i][c].pe = samp;
            m[i][c].ne = !samp;
            m[i][c].h = 0;
          end
        end else begin
          m[i][c].run = 0;
        end
        held = m[i][c].lvl && !m[i][c].pulse &&
               (m[i][c].run == 0);
        if (held) m[i][c].h++;
        m[i][c].rp = held && (dly[i] > 0) &&
          (m[i][c].h >= dly[i]) &&
          ((m[i][c].h - dly[i]) % PER == 0);
        m[i][c].st = m[i][c].lvl;
      end
    end
  endtask

  task automatic chk(string tag, logic [1:0] got,
                     logic [1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b",
             tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic compare();
    chk("a_state", ifa.pb_state,
        {m[0][1].st, m[0][0].st});
    chk("a_pe", ifa.pb_posedge,
        {m[0][1].pe, m[0][0].pe});
    chk("a_ne", ifa.pb_negedge,
        {m[0][1].ne, m[0][0].ne});
    chk("a_rp", ifa.pb_repeat,
        {m[0][1].rp, m[0][0].rp});
    chk("b_state", ifb.pb_state,
        {m[1][1].st, m[1][0].st});
    chk("b_pe", ifb.pb_posedge,
        {m[1][1].pe, m[1][0].pe});
    chk("b_ne", ifb.pb_negedge,
        {m[1][1].ne, m[1][0].ne});
    chk("b_rp", ifb.pb_repeat,
        {m[1][1].rp, m[1][0].rp});
  endtask

  task automatic stats();
    for (int c = 0; c < 2; c++) begin
      if (ifa.pb_posedge[c]) begin
        n_pe[c]++;
        pe_cyc[c] = cyc;
      end
      if (ifa.pb_negedge[c]) begin
        n_ne[c]++;
        ne_cyc[c] = cyc;
      end
      if (ifa.pb_repeat[c]) begin
        if (n_rp[c] == 0) rp_cyc[c] = cyc;
        n_rp[c]++;
      end
      if (ifa.pb_state[c]) n_st[c]++;
    end
    if (ifa.pb_posedge == 2'b11) n_both++;
    if (ifb.pb_posedge[0]) begin
      nb_pe++;
      nb_pe_cyc = cyc;
    end
    if (ifb.pb_negedge[0]) nb_ne++;
    if (ifb.pb_repeat != 2'b00) nb_rp++;
    if (ifb.pb_state[0]) nb_st++;
  endtask

  task automatic clr();
    for (int c = 0; c < 2; c++) begin
      n_pe[c] = 0; n_ne[c] = 0;
      n_rp[c] = 0; n_st[c] = 0;
      pe_cyc[c] = -1; ne_cyc[c] = -1;
      rp_cyc[c] = -1;
    end
    n_both = 0;
    nb_pe = 0; nb_ne = 0; nb_rp = 0; nb_st = 0;
    nb_pe_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare();
    stats();
  endtask

  int rem [2][2];

  initial begin
    ifa.pb = 2'b00;
    ifb.pb = 2'b11;
    rst = 1'b1;
    clr();
    repeat (3) tick();
    chk("rst_state", ifa.pb_state, 2'b00);
    chk("rst_pe", ifa.pb_posedge, 2'b00);
    rst = 1'b0;
    repeat (3) tick();

    // clean press, long hold, release
    clr();
    ifa.pb = 2'b01;
    t0 = cyc + 1;
    repeat (46) tick();
    ifa.pb = 2'b00;
    t1 = cyc + 1;
    repeat (12) tick();
    chk_int("s1_pe_n", n_pe[0], 1);
    chk_int("s1_pe_lat", pe_cyc[0] - t0, 6);
    chk_int("s1_rp_n", n_rp[0], 4);
    chk_int("s1_rp_first", rp_cyc[0] - pe_cyc[0], 20);
    chk_int("s1_ne_n", n_ne[0], 1);
    chk_int("s1_ne_lat", ne_cyc[0] - t1, 6);
    chk_int("s1_st_len", n_st[0], 46);

    // press bounce
    clr();
    ifa.pb = 2'b01; tick();
    ifa.pb = 2'b00; tick();
    ifa.pb = 2'b01; tick();
    ifa.pb = 2'b00; tick();
    ifa.pb = 2'b01;
    t0 = cyc + 1;
    repeat (14) tick();
    chk_int("s2_pe_n", n_pe[0], 1);
    chk_int("s2_pe_lat", pe_cyc[0] - t0, 6);
    chk_int("s2_rp_n", n_rp[0], 0);

    // release bounce
    clr();
    ifa.pb = 2'b00; tick();
    ifa.pb = 2'b01; tick();
    ifa.pb = 2'b00; tick();
    ifa.pb = 2'b01; tick();
    ifa.pb = 2'b00;
    t1 = cyc + 1;
    repeat (14) tick();
    chk_int("s2_ne_n", n_ne[0], 1);
    chk_int("s2_ne_lat", ne_cyc[0] - t1, 6);
    chk_int("s2_pe_none", n_pe[0], 0);

    // short glitch on ch1
    clr();
    ifa.pb = 2'b10;
    repeat (3) tick();
    ifa.pb = 2'b00;
    repeat (15) tick();
    chk_int("s3_pe", n_pe[0] + n_pe[1], 0);
    chk_int("s3_ne", n_ne[0] + n_ne[1], 0);
    chk_int("s3_st", n_st[0] + n_st[1], 0);

    // reset while held, repeat counter at 15
    ifa.pb = 2'b01;
    t0 = cyc + 1;
    repeat (23) tick();
    clr();
    rst = 1'b1;
    tick();
    chk("s4_rst_st", ifa.pb_state, 2'b00);
    chk("s4_rst_ne", ifa.pb_negedge, 2'b00);
    chk("s4_rst_rp", ifa.pb_repeat, 2'b00);
    rst = 1'b0;
    t1 = cyc + 1;
    repeat (30) tick();
    chk_int("s4_ne_n", n_ne[0], 0);
    chk_int("s4_pe_n", n_pe[0], 1);
    chk_int("s4_pe_lat", pe_cyc[0] - t1, 6);
    chk_int("s4_rp_first", rp_cyc[0] - pe_cyc[0], 20);
    ifa.pb = 2'b00;
    repeat (12) tick();

    // simultaneous press, release ch1 only
    clr();
    ifa.pb = 2'b11;
    repeat (16) tick();
    ifa.pb = 2'b01;
    repeat (30) tick();
    chk_int("s5_both", n_both, 1);
    chk_int("s5_ne1", n_ne[1], 1);
    chk_int("s5_ne0", n_ne[0], 0);
    chk_int("s5_rp0", n_rp[0], 4);
    chk_int("s5_rp1", n_rp[1], 0);
    ifa.pb = 2'b00;
    repeat (12) tick();

    // active-low pads, repeat disabled
    clr();
    ifb.pb = 2'b10;
    t0 = cyc + 1;
    repeat (30) tick();
    ifb.pb = 2'b11;
    repeat (12) tick();
    chk_int("s6_pe_n", nb_pe, 1);
    chk_int("s6_pe_lat", nb_pe_cyc - t0, 6);
    chk_int("s6_rp_n", nb_rp, 0);
    chk_int("s6_st_len", nb_st, 30);
    chk_int("s6_ne_n", nb_ne, 1);

    // random runs with occasional reset
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) rem[i][c] = 1;
    repeat (600) begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 2; c++) begin
          rem[i][c]--;
          if (rem[i][c] == 0) begin
            if (i == 0) ifa.pb[c] = ~ifa.pb[c];
            else ifb.pb[c] = ~ifb.pb[c];
            rem[i][c] = $urandom_range(1, 40);
          end
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
